// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions, so the dispatcher, reservation station,
// load/store buffer and the RoB agree on index width, tags and entry types.
package reorder_buffer_pkg;

  localparam int RoB_WIDTH = 4;
  localparam int RoB_SIZE  = 1 << RoB_WIDTH;

  localparam logic [RoB_WIDTH:0] NON_DEP    = (RoB_WIDTH + 1)'(RoB_SIZE);
  localparam logic [RoB_WIDTH:0] FULL_COUNT = (RoB_WIDTH + 1)'(RoB_SIZE);

  typedef enum logic [1:0] {
    ROB_ALU    = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_JALR   = 2'd2,
    ROB_STORE  = 2'd3
  } rob_type_e;

  function automatic logic branch_mispredict(input logic [31:0] value, input logic pred_taken);
    return value[0] != pred_taken;
  endfunction

endpackage

// File: rtl/reorder_buffer_checker.sv
// Protocol checks on the reorder-buffer writeback inputs.
module rob_checker
  import reorder_buffer_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  input logic                 rdy,
  input logic                 rob_en,
  input logic [RoB_WIDTH-1:0] rob_index,
  input logic                 cdb_en,
  input logic [RoB_WIDTH-1:0] cdb_index
);

  a_distinct_writeback_index: assert property (
    @(posedge clk) disable iff (rst)
      (rdy && rob_en && cdb_en) |-> (rob_index != cdb_index)
  );

endmodule

// File: rtl/reorder_buffer_query_port.sv
// One operand lookup: stored result of a finished entry, else a bypass from
// this cycle's writeback buses. Returns not-ready during a flush pulse.
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic [RoB_WIDTH:0]   tag,
  input  logic                 flush,
  input  logic [RoB_SIZE-1:0]  entry_ready,
  input  logic [31:0]          entry_value [RoB_SIZE],
  input  logic                 rob_en,
  input  logic [RoB_WIDTH-1:0] rob_index,
  input  logic [31:0]          rob_data,
  input  logic                 cdb_en,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_data,
  output logic                 ready,
  output logic [31:0]          data
);

  logic [RoB_WIDTH-1:0] idx;
  assign idx = tag[RoB_WIDTH-1:0];

  // Any tag with the top bit set (NON_DEP included) never names an entry.
  always_comb begin
    ready = 1'b0;
    data  = 32'd0;
    if (flush || tag[RoB_WIDTH]) begin
      ready = 1'b0;
      data  = 32'd0;
    end else if (entry_ready[idx]) begin
      ready = 1'b1;
      data  = entry_value[idx];
    end else if (cdb_en && (cdb_index == idx)) begin
      ready = 1'b1;
      data  = cdb_data;
    end else if (rob_en && (rob_index == idx)) begin
      ready = 1'b1;
      data  = rob_data;
    end else begin
      ready = 1'b0;
      data  = 32'd0;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order retirement, writeback capture,
// operand lookup with bypass, and branch/jalr redirect with a global flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_en,
  input  logic [1:0]           alloc_type,
  input  logic [4:0]           alloc_rd,
  input  logic [31:0]          alloc_pc,
  input  logic [31:0]          alloc_target,
  input  logic                 alloc_pred_taken,
  output logic [RoB_WIDTH-1:0] alloc_index,
  output logic                 isFull,
  output logic                 isEmpty,
  input  logic                 RoB_update_en,
  input  logic [RoB_WIDTH-1:0] RoB_update_index,
  input  logic [31:0]          RoB_update_data,
  input  logic                 CDB_update_en,
  input  logic [RoB_WIDTH-1:0] CDB_update_index,
  input  logic [31:0]          CDB_update_data,
  input  logic [RoB_WIDTH:0]   query_j_tag,
  input  logic [RoB_WIDTH:0]   query_k_tag,
  output logic                 query_j_ready,
  output logic                 query_k_ready,
  output logic [31:0]          query_j_data,
  output logic [31:0]          query_k_data,
  output logic                 commit_en,
  output logic [RoB_WIDTH-1:0] commit_index,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_data,
  output logic                 store_commit_en,
  output logic                 flush_signal,
  output logic [31:0]          redirect_pc
);

  logic [RoB_WIDTH-1:0] head;
  logic [RoB_WIDTH-1:0] tail;
  logic [RoB_WIDTH:0]   count;
  logic [RoB_SIZE-1:0]  busy;
  logic [RoB_SIZE-1:0]  done;
  rob_type_e            etype      [RoB_SIZE];
  logic [4:0]           rd         [RoB_SIZE];
  logic [31:0]          pc         [RoB_SIZE];
  logic [31:0]          target     [RoB_SIZE];
  logic                 pred_taken [RoB_SIZE];
  logic [31:0]          value      [RoB_SIZE];

  logic alloc_ok;
  logic commit_ok;

  assign isFull      = (count == FULL_COUNT);
  assign isEmpty     = (count == '0);
  assign alloc_index = tail;
  assign alloc_ok    = alloc_en & ~isFull;
  assign commit_ok   = busy[head] & done[head];

  // Entry state, pointers and the registered retire/redirect outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      busy            <= '0;
      done            <= '0;
      commit_en       <= 1'b0;
      commit_index    <= '0;
      commit_rd       <= 5'd0;
      commit_data     <= 32'd0;
      store_commit_en <= 1'b0;
      flush_signal    <= 1'b0;
      redirect_pc     <= 32'd0;
    end else if (rdy_in) begin
      commit_en       <= 1'b0;
      store_commit_en <= 1'b0;
      flush_signal    <= 1'b0;
      if (flush_signal) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        done  <= '0;
      end else begin
        // CDB is written second so it wins a (disallowed) same-index collision.
        if (RoB_update_en && busy[RoB_update_index]) begin
          done[RoB_update_index]  <= 1'b1;
          value[RoB_update_index] <= RoB_update_data;
        end
        if (CDB_update_en && busy[CDB_update_index]) begin
          done[CDB_update_index]  <= 1'b1;
          value[CDB_update_index] <= CDB_update_data;
        end
        if (commit_ok) begin
          busy[head]   <= 1'b0;
          done[head]   <= 1'b0;
          head         <= head + RoB_WIDTH'(1);
          commit_en    <= 1'b1;
          commit_index <= head;
          case (etype[head])
            ROB_ALU: begin
              commit_rd   <= rd[head];
              commit_data <= value[head];
            end
            ROB_BRANCH: begin
              commit_rd   <= 5'd0;
              commit_data <= value[head];
              if (branch_mispredict(value[head], pred_taken[head])) begin
                flush_signal <= 1'b1;
                redirect_pc  <= value[head][0] ? target[head] : pc[head] + 32'd4;
              end
            end
            ROB_JALR: begin
              commit_rd    <= rd[head];
              commit_data  <= pc[head] + 32'd4;
              flush_signal <= 1'b1;
              redirect_pc  <= value[head];
            end
            ROB_STORE: begin
              commit_rd       <= 5'd0;
              commit_data     <= value[head];
              store_commit_en <= 1'b1;
            end
            default: begin
              commit_rd   <= 5'd0;
              commit_data <= value[head];
            end
          endcase
        end
        if (alloc_ok) begin
          busy[tail]       <= 1'b1;
          done[tail]       <= 1'b0;
          etype[tail]      <= rob_type_e'(alloc_type);
          rd[tail]         <= alloc_rd;
          pc[tail]         <= alloc_pc;
          target[tail]     <= alloc_target;
          pred_taken[tail] <= alloc_pred_taken;
          tail             <= tail + RoB_WIDTH'(1);
        end
        count <= count + {{RoB_WIDTH{1'b0}}, alloc_ok} - {{RoB_WIDTH{1'b0}}, commit_ok};
      end
    end
  end

  rob_query_port u_query_j (
    .tag         (query_j_tag),
    .flush       (flush_signal),
    .entry_ready (busy & done),
    .entry_value (value),
    .rob_en      (RoB_update_en),
    .rob_index   (RoB_update_index),
    .rob_data    (RoB_update_data),
    .cdb_en      (CDB_update_en),
    .cdb_index   (CDB_update_index),
    .cdb_data    (CDB_update_data),
    .ready       (query_j_ready),
    .data        (query_j_data)
  );

  rob_query_port u_query_k (
    .tag         (query_k_tag),
    .flush       (flush_signal),
    .entry_ready (busy & done),
    .entry_value (value),
    .rob_en      (RoB_update_en),
    .rob_index   (RoB_update_index),
    .rob_data    (RoB_update_data),
    .cdb_en      (CDB_update_en),
    .cdb_index   (CDB_update_index),
    .cdb_data    (CDB_update_data),
    .ready       (query_k_ready),
    .data        (query_k_data)
  );

  rob_checker u_checker (
    .clk       (clk_in),
    .rst       (rst_in),
    .rdy       (rdy_in),
    .rob_en    (RoB_update_en),
    .rob_index (RoB_update_index),
    .cdb_en    (CDB_update_en),
    .cdb_index (CDB_update_index)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario bench for reorder_buffer: expected retirements are queued when the
// stimulus is driven and matched against each commit pulse as it appears.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, alloc_en, alloc_pred_taken;
  logic [1:0]  alloc_type;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc, alloc_target;
  logic [3:0]  alloc_index;
  logic        isFull, isEmpty;
  logic        RoB_update_en, CDB_update_en;
  logic [3:0]  RoB_update_index, CDB_update_index;
  logic [31:0] RoB_update_data, CDB_update_data;
  logic [4:0]  query_j_tag, query_k_tag;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_data, query_k_data;
  logic        commit_en, store_commit_en, flush_signal;
  logic [3:0]  commit_index;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, redirect_pc;

  typedef struct {
    logic [3:0]  idx;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        store;
    logic        flush;
    logic [31:0] redir;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_en(alloc_en), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_target(alloc_target), .alloc_pred_taken(alloc_pred_taken),
    .alloc_index(alloc_index), .isFull(isFull), .isEmpty(isEmpty),
    .RoB_update_en(RoB_update_en), .RoB_update_index(RoB_update_index), .RoB_update_data(RoB_update_data),
    .CDB_update_en(CDB_update_en), .CDB_update_index(CDB_update_index), .CDB_update_data(CDB_update_data),
    .query_j_tag(query_j_tag), .query_k_tag(query_k_tag),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_data(query_j_data), .query_k_data(query_k_data),
    .commit_en(commit_en), .commit_index(commit_index), .commit_rd(commit_rd),
    .commit_data(commit_data), .store_commit_en(store_commit_en),
    .flush_signal(flush_signal), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // One clock; any fresh commit pulse is matched against the scoreboard.
  task automatic step();
    bit   live;
    bit   ok;
    exp_t e;
    live = rdy_in && !rst_in;
    @(posedge clk_in);
    #1;
    if (live && commit_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL commit_unexpected: index=%0d rd=%0d data=%h flush=%b, required no commit",
                 commit_index, commit_rd, commit_data, flush_signal);
      end else begin
        e  = exp_q.pop_front();
        ok = (commit_index === e.idx) && (commit_rd === e.rd) &&
             (store_commit_en === e.store) && (flush_signal === e.flush);
        if (e.chk_data) ok = ok && (commit_data === e.data);
        if (e.flush) ok = ok && (redirect_pc === e.redir);
        if (!ok) begin
          fails++;
          $display("FAIL commit: got idx=%0d rd=%0d data=%h st=%b fl=%b pc=%h, required idx=%0d rd=%0d data=%h st=%b fl=%b pc=%h",
                   commit_index, commit_rd, commit_data, store_commit_en, flush_signal, redirect_pc,
                   e.idx, e.rd, e.data, e.store, e.flush, e.redir);
        end
      end
    end else if (live && (flush_signal || store_commit_en)) begin
      tests++;
      fails++;
      $display("FAIL spurious_pulse: flush=%b store=%b without commit, required 0", flush_signal, store_commit_en);
    end
  endtask

  task automatic idle_inputs();
    alloc_en      = 1'b0;
    RoB_update_en = 1'b0;
    CDB_update_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    exp_q.delete();
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pred);
    alloc_en = 1'b1; alloc_type = t; alloc_rd = rd;
    alloc_pc = pc; alloc_target = tgt; alloc_pred_taken = pred;
    step();
    alloc_en = 1'b0;
  endtask

  task automatic expect_commit(input logic [3:0] idx, input logic [4:0] rd, input logic [31:0] data,
                               input logic chk_data, input logic store, input logic flush,
                               input logic [31:0] redir);
    exp_t e;
    e.idx = idx; e.rd = rd; e.data = data; e.chk_data = chk_data;
    e.store = store; e.flush = flush; e.redir = redir;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d commits pending after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (commit_en !== 1'b0 || flush_signal !== 1'b0 || store_commit_en !== 1'b0 ||
        commit_data !== 32'd0 || redirect_pc !== 32'd0 || commit_rd !== 5'd0) begin
      fails++;
      $display("FAIL reset_outputs: ce=%b fl=%b st=%b data=%h pc=%h rd=%0d, required all 0",
               commit_en, flush_signal, store_commit_en, commit_data, redirect_pc, commit_rd);
    end
    tests++;
    if (isEmpty !== 1'b1 || isFull !== 1'b0 || alloc_index !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: empty=%b full=%b idx=%0d, required 1 0 0", isEmpty, isFull, alloc_index);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    alloc(2'd0, 5'd1, 32'h10, 32'h0, 1'b0);
    alloc(2'd0, 5'd2, 32'h14, 32'h0, 1'b0);
    alloc(2'd0, 5'd3, 32'h18, 32'h0, 1'b0);
    tests++;
    if (alloc_index !== 4'd3) begin
      fails++;
      $display("FAIL alloc_index: got %0d, required 3", alloc_index);
    end
    expect_commit(4'd0, 5'd1, 32'hB, 1'b1, 1'b0, 1'b0, 32'd0);
    expect_commit(4'd1, 5'd2, 32'hC, 1'b1, 1'b0, 1'b0, 32'd0);
    expect_commit(4'd2, 5'd3, 32'hA, 1'b1, 1'b0, 1'b0, 32'd0);
    RoB_update_en = 1'b1; RoB_update_index = 4'd2; RoB_update_data = 32'hA; step();
    RoB_update_index = 4'd0; RoB_update_data = 32'hB; step();
    RoB_update_index = 4'd1; RoB_update_data = 32'hC; step();
    RoB_update_en = 1'b0;
    wait_drain(10);
    tests++;
    if (isEmpty !== 1'b1) begin
      fails++;
      $display("FAIL in_order_empty: got %b, required 1", isEmpty);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) alloc(2'd0, 5'(i + 1), 32'(i * 4), 32'd0, 1'b0);
    tests++;
    if (isFull !== 1'b1 || alloc_index !== 4'd0) begin
      fails++;
      $display("FAIL full: full=%b idx=%0d, required 1 0", isFull, alloc_index);
    end
    RoB_update_en = 1'b1; RoB_update_index = 4'd0; RoB_update_data = 32'h55;
    step();
    RoB_update_en = 1'b0;
    expect_commit(4'd0, 5'd1, 32'h55, 1'b1, 1'b0, 1'b0, 32'd0);
    alloc_en = 1'b1; alloc_type = 2'd0; alloc_rd = 5'd20;
    step();
    tests++;
    if (isFull !== 1'b0 || alloc_index !== 4'd0) begin
      fails++;
      $display("FAIL full_alloc_ignored: full=%b idx=%0d, required 0 0", isFull, alloc_index);
    end
    step();
    alloc_en = 1'b0;
    tests++;
    if (isFull !== 1'b1 || alloc_index !== 4'd1) begin
      fails++;
      $display("FAIL wrap_alloc: full=%b idx=%0d, required 1 1", isFull, alloc_index);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL full_commit: %0d commits pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    alloc(2'd1, 5'd9, 32'h100, 32'h140, 1'b0);
    alloc(2'd0, 5'd4, 32'h104, 32'd0, 1'b0);
    alloc(2'd0, 5'd5, 32'h108, 32'd0, 1'b0);
    alloc(2'd0, 5'd6, 32'h10C, 32'd0, 1'b0);
    RoB_update_en = 1'b1; RoB_update_index = 4'd1; RoB_update_data = 32'h11;
    CDB_update_en = 1'b1; CDB_update_index = 4'd2; CDB_update_data = 32'h22;
    step();
    CDB_update_en = 1'b0;
    RoB_update_index = 4'd3; RoB_update_data = 32'h33;
    step();
    RoB_update_en = 1'b0;
    query_j_tag = 5'd1;
    #1;
    tests++;
    if (query_j_ready !== 1'b1 || query_j_data !== 32'h11) begin
      fails++;
      $display("FAIL query_done: ready=%b data=%h, required 1 00000011", query_j_ready, query_j_data);
    end
    expect_commit(4'd0, 5'd0, 32'd1, 1'b0, 1'b0, 1'b1, 32'h140);
    RoB_update_en = 1'b1; RoB_update_index = 4'd0; RoB_update_data = 32'd1;
    step();
    RoB_update_en = 1'b0;
    wait_drain(3);
    #1;
    tests++;
    if (query_j_ready !== 1'b0) begin
      fails++;
      $display("FAIL query_in_flush: ready=%b, required 0", query_j_ready);
    end
    step();
    tests++;
    if (isEmpty !== 1'b1 || alloc_index !== 4'd0 || flush_signal !== 1'b0) begin
      fails++;
      $display("FAIL after_flush: empty=%b idx=%0d flush=%b, required 1 0 0", isEmpty, alloc_index, flush_signal);
    end
    for (int i = 0; i < 5; i++) step();
    query_j_tag = 5'd16;
  endtask

  task automatic test_jalr();
    do_reset();
    alloc(2'd2, 5'd1, 32'h200, 32'd0, 1'b0);
    expect_commit(4'd0, 5'd1, 32'h204, 1'b1, 1'b0, 1'b1, 32'h3000);
    RoB_update_en = 1'b1; RoB_update_index = 4'd0; RoB_update_data = 32'h3000;
    step();
    RoB_update_en = 1'b0;
    wait_drain(5);
    step();
    tests++;
    if (isEmpty !== 1'b1) begin
      fails++;
      $display("FAIL jalr_empty: got %b, required 1", isEmpty);
    end
  endtask

  task automatic test_store_branch();
    do_reset();
    alloc(2'd3, 5'd9, 32'h10, 32'd0, 1'b0);
    alloc(2'd1, 5'd8, 32'h300, 32'h400, 1'b1);
    alloc(2'd1, 5'd7, 32'h500, 32'h600, 1'b1);
    expect_commit(4'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    expect_commit(4'd1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    expect_commit(4'd2, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h504);
    CDB_update_en = 1'b1; CDB_update_index = 4'd0; CDB_update_data = 32'hDEAD;
    RoB_update_en = 1'b1; RoB_update_index = 4'd1; RoB_update_data = 32'd1;
    step();
    CDB_update_en = 1'b0;
    RoB_update_index = 4'd2; RoB_update_data = 32'd0;
    step();
    RoB_update_en = 1'b0;
    wait_drain(10);
    step();
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 6; i++) alloc(2'd0, 5'(i + 10), 32'(i * 4), 32'd0, 1'b0);
    RoB_update_en = 1'b1; RoB_update_index = 4'd5; RoB_update_data = 32'h77;
    CDB_update_en = 1'b1; CDB_update_index = 4'd3; CDB_update_data = 32'h99;
    query_j_tag = 5'd5; query_k_tag = 5'd3;
    #1;
    tests++;
    if (query_j_ready !== 1'b1 || query_j_data !== 32'h77 || query_k_ready !== 1'b1 || query_k_data !== 32'h99) begin
      fails++;
      $display("FAIL query_bypass: j=%b/%h k=%b/%h, required 1/00000077 1/00000099",
               query_j_ready, query_j_data, query_k_ready, query_k_data);
    end
    query_k_tag = 5'd16;
    #1;
    tests++;
    if (query_k_ready !== 1'b0) begin
      fails++;
      $display("FAIL query_non_dep: ready=%b, required 0", query_k_ready);
    end
    step();
    idle_inputs();
    query_k_tag = 5'd4;
    #1;
    tests++;
    if (query_j_ready !== 1'b1 || query_j_data !== 32'h77 || query_k_ready !== 1'b0 || query_k_data !== 32'd0) begin
      fails++;
      $display("FAIL query_stored: j=%b/%h k=%b/%h, required 1/00000077 0/00000000",
               query_j_ready, query_j_data, query_k_ready, query_k_data);
    end
    query_j_tag = 5'd16; query_k_tag = 5'd16;
  endtask

  task automatic test_rdy_hold();
    do_reset();
    alloc(2'd0, 5'd7, 32'h40, 32'd0, 1'b0);
    RoB_update_en = 1'b1; RoB_update_index = 4'd0; RoB_update_data = 32'h1234;
    step();
    RoB_update_en = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (commit_en !== 1'b0 || isEmpty !== 1'b0) begin
        fails++;
        $display("FAIL rdy_stall: commit=%b empty=%b, required 0 0", commit_en, isEmpty);
      end
    end
    rdy_in = 1'b1;
    expect_commit(4'd0, 5'd7, 32'h1234, 1'b1, 1'b0, 1'b0, 32'd0);
    wait_drain(3);
    rdy_in = 1'b0;
    step();
    tests++;
    if (commit_en !== 1'b1 || commit_rd !== 5'd7) begin
      fails++;
      $display("FAIL rdy_hold_pulse: commit=%b rd=%0d, required 1 7", commit_en, commit_rd);
    end
    rdy_in = 1'b1;
    step();
    tests++;
    if (commit_en !== 1'b0) begin
      fails++;
      $display("FAIL pulse_clear: commit=%b, required 0", commit_en);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc(2'd0, 5'd3, 32'h80, 32'd0, 1'b0);
    alloc(2'd0, 5'd4, 32'h84, 32'd0, 1'b0);
    RoB_update_en = 1'b1; RoB_update_index = 4'd0; RoB_update_data = 32'hAA;
    CDB_update_en = 1'b1; CDB_update_index = 4'd1; CDB_update_data = 32'hBB;
    step();
    idle_inputs();
    expect_commit(4'd0, 5'd3, 32'hAA, 1'b1, 1'b0, 1'b0, 32'd0);
    wait_drain(2);
    rst_in = 1'b1;
    step();
    query_j_tag = 5'd1;
    #1;
    tests++;
    if (commit_en !== 1'b0 || commit_rd !== 5'd0 || commit_data !== 32'd0 || commit_index !== 4'd0 ||
        flush_signal !== 1'b0 || store_commit_en !== 1'b0 || redirect_pc !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: ce=%b rd=%0d data=%h idx=%0d fl=%b st=%b pc=%h, required all 0",
               commit_en, commit_rd, commit_data, commit_index, flush_signal, store_commit_en, redirect_pc);
    end
    tests++;
    if (isEmpty !== 1'b1 || alloc_index !== 4'd0 || query_j_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_state: empty=%b idx=%0d qready=%b, required 1 0 0", isEmpty, alloc_index, query_j_ready);
    end
    rst_in = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    alloc_en = 1'b0; alloc_type = 2'd0; alloc_rd = 5'd0;
    alloc_pc = 32'd0; alloc_target = 32'd0; alloc_pred_taken = 1'b0;
    RoB_update_en = 1'b0; RoB_update_index = 4'd0; RoB_update_data = 32'd0;
    CDB_update_en = 1'b0; CDB_update_index = 4'd0; CDB_update_data = 32'd0;
    query_j_tag = 5'd16; query_k_tag = 5'd16;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_branch_flush();
    test_jalr();
    test_store_branch();
    test_query_bypass();
    test_rdy_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue, 16 entries, indexed by RoB entry number.
- Receives allocations from the dispatcher. Receives results from the reservation station's RoB_update_* port and from the load/store buffer's CDB broadcast.
- Answers operand lookups for the dispatcher.
- Retires one entry per cycle to the register file. Detects branch and jalr redirects and drives the global flush_signal consumed by the reservation station.

Parameters:
- RoB_WIDTH, 4, index width.
- RoB_SIZE, 1 << RoB_WIDTH, entry count.
- NON_DEP, 1 << RoB_WIDTH, "no dependency" tag value (RoB_WIDTH+1 bits).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global enable; 0 holds all state.
- alloc_en  input  1  dispatcher allocates the tail entry.
- alloc_type  input  2  0=ALU (writes rd), 1=BRANCH, 2=JALR, 3=STORE.
- alloc_rd  input  5  destination register.
- alloc_pc  input  32  instruction pc.
- alloc_target  input  32  pc+imm for branches.
- alloc_pred_taken  input  1  predictor decision.
- alloc_index  output  RoB_WIDTH  current tail, the entry number given to the new instruction.
- isFull  output  1  count == RoB_SIZE.
- isEmpty  output  1  count == 0.
- RoB_update_en / RoB_update_index / RoB_update_data  input  1/RoB_WIDTH/32  ALU result from the reservation station.
- CDB_update_en / CDB_update_index / CDB_update_data  input  1/RoB_WIDTH/32  load/store result.
- query_j_tag, query_k_tag  input  RoB_WIDTH+1  operand tags to look up.
- query_j_ready, query_k_ready  output  1  value available.
- query_j_data, query_k_data  output  32  looked-up value.
- commit_en  output  1  one-cycle retire pulse.
- commit_index  output  RoB_WIDTH  retired entry.
- commit_rd  output  5  retired rd; 0 for BRANCH and STORE.
- commit_data  output  32  value written to rd.
- store_commit_en  output  1  pulse when a STORE retires.
- flush_signal  output  1  one-cycle redirect pulse.
- redirect_pc  output  32  fetch restart address.

Behaviour:
- Reset, and any cycle with rst_in high: head=tail=count=0, all busy/done cleared. All outputs 0, except query_*_ready, which follows its combinational rule.
- rdy_in=0 and rst_in=0: no state change. Registered pulse outputs hold.
- Per entry state: busy, done, type, rd, pc, target, pred_taken, value.
- Allocation:
  - Accepted only when alloc_en=1 and isFull=0.
  - isFull is taken from the registered count, so a commit in the same cycle does not free space.
  - Writes the entry at tail with busy=1, done=0. tail wraps modulo RoB_SIZE.
  - alloc_en while full is ignored silently.
- Writeback:
  - RoB_update_en and CDB_update_en are independent. Each sets done=1 and value=data on its indexed entry, if busy.
  - Both may arrive in the same cycle on different indices.
  - Same index on both: CDB wins. This is illegal in practice and is flagged by an assertion.
- Query, combinational:
  - tag == NON_DEP gives ready=0.
  - Tag matches a done entry: ready=1, data=value.
  - Tag matches this cycle's RoB_update or CDB_update index: bypass, ready=1, data from the bus.
  - Otherwise ready=0, data=0.
- Commit:
  - Occurs when head is busy and done at the clock edge. Writeback done in cycle N is retired in cycle N+1 at the earliest.
  - Drives the commit_* outputs for one cycle, clears head, increments head.
  - count updates as +alloc −commit; simultaneous alloc and commit leaves count unchanged.
- ALU commit: commit_rd=rd, commit_data=value.
- STORE commit: store_commit_en=1, commit_rd=0.
- BRANCH commit: value[0] is the actual taken bit; commit_rd=0.
  - If value[0] != pred_taken: flush_signal=1, redirect_pc = taken ? target : pc+4.
- JALR commit: commit_rd=rd, commit_data=pc+4. Always flush_signal=1 with redirect_pc = value (bit 0 already cleared).
- Flush:
  - The cycle after flush_signal is asserted, the buffer is empty: head=tail=count=0, all entries invalid.
  - Allocations, writebacks and queries presented during the flush-pulse cycle are discarded or return ready=0.
- Pulse outputs (commit_en, store_commit_en, flush_signal) default to 0 every enabled cycle.
- Arithmetic is 32-bit wrap-around. Index arithmetic is modulo RoB_SIZE.

Decomposition:
- Shared package holds:
  - the RoB entry-type encodings (ALU/BRANCH/JALR/STORE);
  - NON_DEP;
  - RoB_WIDTH, so the dispatcher, reservation station, LSB and this block agree.
- Sub-module rob_query_port: one tag lookup plus bypass, instantiated twice for the j and k operands.

Test Plan:
- Reset, then allocate 3 ALU entries (rd=1,2,3), writeback indices 2,0,1 with values 0xA,0xB,0xC → commits in order 0,1,2 with rd 1,2,3 and data 0xB,0xC,0xA; isEmpty=1 after.
- Allocate 16 entries → isFull=1, alloc_index=0. Then alloc_en with a same-cycle commit of entry 0 → allocation ignored; the next cycle's allocation succeeds at index 0 (wrap).
- BRANCH pc=0x100, target=0x140, pred_taken=0, written back value 1 → flush_signal=1, redirect_pc=0x140. Next cycle isEmpty=1, and younger entries 1..3 never commit.
- JALR rd=1, pc=0x200, value 0x3000 → commit_data=0x204, commit_rd=1, flush_signal=1, redirect_pc=0x3000.
- query_j_tag=5 in the same cycle as RoB_update_index=5, data 0x77 → query_j_ready=1, data 0x77. Tag=NON_DEP → ready=0.
- rdy_in=0 while head is done → no commit until rdy_in returns. Reset asserted mid-stream → all outputs 0, count=0.
